// File: rtl/cnn_pkg.sv
// Shared constants and FSM encoding for the CNN classifier back end.
// Latency: n/a (package). Backpressure: n/a.
// Widths are fixed by the ten-score port list of the L2 stage.
package cnn_pkg;

    localparam int NUM_CLASSES = 10;
    localparam int DATA_W      = 8;
    localparam int IDX_W       = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } argmax_state_t;

endpackage

// File: rtl/argmax_cmp.sv
// Strict greater-than comparator for class scores, signed or unsigned.
// Latency: combinational. Backpressure: none.
// Ties report 0 so the scan keeps the earlier index.
module argmax_cmp #(
    parameter int DATA_W = 8,
    parameter bit SIGNED = 1'b1
) (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic              a_gt_b
);

    assign a_gt_b = SIGNED ? ($signed(a) > $signed(b)) : (a > b);

endmodule

// File: rtl/l2_argmax_classify.sv
// Sequential arg-max over the ten L2 class scores; optional margin output under ARGMAX_MARGIN_EN.
// Latency: out_valid rises on the 10th rising edge after the capture edge.
// Backpressure: result held in DONE until out_ready; in_ready only in IDLE, no input queueing.
module l2_argmax_classify
    import cnn_pkg::*;
#(
    parameter bit SIGNED = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] num_0,
    input  logic [DATA_W-1:0] num_1,
    input  logic [DATA_W-1:0] num_2,
    input  logic [DATA_W-1:0] num_3,
    input  logic [DATA_W-1:0] num_4,
    input  logic [DATA_W-1:0] num_5,
    input  logic [DATA_W-1:0] num_6,
    input  logic [DATA_W-1:0] num_7,
    input  logic [DATA_W-1:0] num_8,
    input  logic [DATA_W-1:0] num_9,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [IDX_W-1:0]  digit,
    output logic [DATA_W-1:0] max_score,
    output logic              busy
`ifdef ARGMAX_MARGIN_EN
    ,
    output logic [DATA_W-1:0] margin
`endif
);

    localparam logic [DATA_W-1:0] TYPE_MIN = SIGNED ? {1'b1, {(DATA_W-1){1'b0}}} : '0;
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NUM_CLASSES);

    argmax_state_t     state_q;
    logic [DATA_W-1:0] score_q [NUM_CLASSES];
    logic [DATA_W-1:0] in_scores [NUM_CLASSES];
    logic [IDX_W-1:0]  idx_q;
    logic [IDX_W-1:0]  best_idx_q;
    logic [DATA_W-1:0] best_val_q;
    logic [DATA_W-1:0] cur_score;
    logic              cur_gt_best;

    assign in_scores = '{num_0, num_1, num_2, num_3, num_4,
                         num_5, num_6, num_7, num_8, num_9};

    always_comb begin
        cur_score = '0;
        for (int i = 0; i < NUM_CLASSES; i++) begin
            if (idx_q == IDX_W'(i)) begin
                cur_score = score_q[i];
            end
        end
    end

    argmax_cmp #(.DATA_W(DATA_W), .SIGNED(SIGNED)) u_cmp_best (
        .a      (cur_score),
        .b      (best_val_q),
        .a_gt_b (cur_gt_best)
    );

`ifdef ARGMAX_MARGIN_EN
    logic [DATA_W-1:0] second_val_q;
    logic              cur_gt_second;
    logic [DATA_W:0]   diff;
    logic [DATA_W-1:0] margin_sat;

    argmax_cmp #(.DATA_W(DATA_W), .SIGNED(SIGNED)) u_cmp_second (
        .a      (cur_score),
        .b      (second_val_q),
        .a_gt_b (cur_gt_second)
    );

    // best >= second always holds, so the widened difference is never negative
    assign diff = SIGNED ? ({best_val_q[DATA_W-1], best_val_q} - {second_val_q[DATA_W-1], second_val_q})
                         : ({1'b0, best_val_q} - {1'b0, second_val_q});
    assign margin_sat = diff[DATA_W] ? '1 : diff[DATA_W-1:0];
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            in_ready   <= 1'b1;
            out_valid  <= 1'b0;
            busy       <= 1'b0;
            digit      <= '0;
            max_score  <= '0;
            idx_q      <= '0;
            best_idx_q <= '0;
            best_val_q <= '0;
            for (int i = 0; i < NUM_CLASSES; i++) begin
                score_q[i] <= '0;
            end
`ifdef ARGMAX_MARGIN_EN
            second_val_q <= TYPE_MIN;
            margin       <= '0;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (in_valid) begin
                        for (int i = 0; i < NUM_CLASSES; i++) begin
                            score_q[i] <= in_scores[i];
                        end
                        best_val_q <= num_0;
                        best_idx_q <= '0;
                        idx_q      <= IDX_W'(1);
                        in_ready   <= 1'b0;
                        busy       <= 1'b1;
                        state_q    <= ST_SCAN;
`ifdef ARGMAX_MARGIN_EN
                        second_val_q <= TYPE_MIN;
`endif
                    end
                end
                ST_SCAN: begin
                    // idx runs past the last class for one commit cycle that loads the result regs
                    if (idx_q == LAST_IDX) begin
                        digit     <= best_idx_q;
                        max_score <= best_val_q;
                        out_valid <= 1'b1;
                        state_q   <= ST_DONE;
`ifdef ARGMAX_MARGIN_EN
                        margin    <= margin_sat;
`endif
                    end else begin
                        if (cur_gt_best) begin
                            best_val_q <= cur_score;
                            best_idx_q <= idx_q;
`ifdef ARGMAX_MARGIN_EN
                            second_val_q <= best_val_q;
                        end else if (cur_gt_second) begin
                            second_val_q <= cur_score;
`endif
                        end
                        idx_q <= idx_q + IDX_W'(1);
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        busy      <= 1'b0;
                        state_q   <= ST_IDLE;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    busy      <= 1'b0;
                    state_q   <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
